// File: rtl/v_sync_if.sv
// Bundles the line-strobe input and VGA timing outputs shared between h_counter,
// v_sync_gen and the pixel pipeline.
interface v_sync_if;
    logic [9:0] h_count;
    logic       trig_v;
    logic [9:0] v_count;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       frame_start;
    logic       sync_err;

    modport master (
        output h_count, trig_v,
        input  v_count, hsync, vsync, video_on, pix_x, pix_y, frame_start, sync_err
    );

    modport slave (
        input  h_count, trig_v,
        output v_count, hsync, vsync, video_on, pix_x, pix_y, frame_start, sync_err
    );
endinterface

// File: rtl/v_sync_gen.sv
// Vertical line counter and phase FSM plus the registered VGA sync stage; every
// output lags h_count/v_count by one clock so pix_x/pix_y line up with the syncs.
module v_sync_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_TOTAL   = 800,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_TOTAL   = 525
) (
    input  logic      clk,
    input  logic      rst,
    v_sync_if.slave   bus
);

    typedef enum logic [1:0] {
        V_ACTIVE,
        V_FRONT,
        V_SYNC_PH,
        V_BACK
    } vState_t;

    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] VF_START = 10'(V_VISIBLE);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VB_START = 10'(V_VISIBLE + V_FP + V_SYNC);

    vState_t    r_state;
    vState_t    w_stateNext;
    logic [9:0] r_vCount;
    logic [9:0] w_vNext;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_videoOn;
    logic [9:0] r_pixX;
    logic [9:0] r_pixY;
    logic       r_frameStart;
    logic       r_syncErr;

    assign w_vNext = (r_vCount == V_LAST) ? 10'd0 : r_vCount + 10'd1;

    // The state names the phase of the line v_count is about to enter.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            V_ACTIVE:  if (bus.trig_v && w_vNext == VF_START) w_stateNext = V_FRONT;
            V_FRONT:   if (bus.trig_v && w_vNext == VS_START) w_stateNext = V_SYNC_PH;
            V_SYNC_PH: if (bus.trig_v && w_vNext == VB_START) w_stateNext = V_BACK;
            V_BACK:    if (bus.trig_v && w_vNext == 10'd0)    w_stateNext = V_ACTIVE;
            default:   w_stateNext = V_ACTIVE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vCount     <= 10'd0;
            r_state      <= V_ACTIVE;
            r_hsync      <= 1'b1;
            r_vsync      <= 1'b1;
            r_videoOn    <= 1'b0;
            r_pixX       <= 10'd0;
            r_pixY       <= 10'd0;
            r_frameStart <= 1'b0;
            r_syncErr    <= 1'b0;
        end else begin
            if (bus.trig_v) begin
                r_vCount <= w_vNext;
            end
            r_state      <= w_stateNext;
            r_hsync      <= ~(bus.h_count >= HS_START && bus.h_count < HS_END);
            r_vsync      <= ~(r_state == V_SYNC_PH);
            r_videoOn    <= (bus.h_count < H_VIS) && (r_state == V_ACTIVE);
            r_pixX       <= bus.h_count;
            r_pixY       <= r_vCount;
            r_frameStart <= (bus.h_count == 10'd0) && (r_vCount == 10'd0);
            // A strobe off the last pixel still advances the count; it is only flagged.
            if (bus.trig_v && bus.h_count != H_LAST) begin
                r_syncErr <= 1'b1;
            end
        end
    end

    assign bus.v_count     = r_vCount;
    assign bus.hsync       = r_hsync;
    assign bus.vsync       = r_vsync;
    assign bus.video_on    = r_videoOn;
    assign bus.pix_x       = r_pixX;
    assign bus.pix_y       = r_pixY;
    assign bus.frame_start = r_frameStart;
    assign bus.sync_err    = r_syncErr;

endmodule

// File: tb/tb_v_sync_gen.sv
// Bench for v_sync_gen: a line/frame arithmetic model predicts every output each
// cycle, and targeted segments pin sync widths, frame wrap and error behaviour.
module tb_v_sync_gen;

    localparam int H_TOTAL = 800;
    localparam int V_TOTAL = 525;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic statOn = 1'b0;

    int checks = 0;
    int failures = 0;

    int mV = 0;
    bit mErr = 1'b0;
    bit mValid = 1'b0;

    int hsLow, voHigh, vsLow, fsCount, wraps, prevV;
    int hsMinX, hsMaxX, voMinX, voMaxX, vsMinY, vsMaxY, fsX, fsY;

    always #5 clk = ~clk;

    v_sync_if bus ();

    v_sync_gen dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [9:0] h, input logic t, input logic r);
        @(negedge clk);
        bus.h_count = h;
        bus.trig_v  = t;
        rst         = r;
    endtask

    task automatic waitOut();
        @(posedge clk);
        #2;
    endtask

    task automatic clearStats();
        hsLow = 0; voHigh = 0; vsLow = 0; fsCount = 0; wraps = 0;
        hsMinX = 1023; hsMaxX = -1; voMinX = 1023; voMaxX = -1;
        vsMinY = 1023; vsMaxY = -1; fsX = -1; fsY = -1;
    endtask

    task automatic fastForward(input int n);
        for (int i = 0; i < n; i++) applyStimulus(10'd799, 1'b1, 1'b0);
    endtask

    task automatic driveLine();
        for (int h = 0; h < H_TOTAL; h++) applyStimulus(10'(h), (h == H_TOTAL - 1), 1'b0);
    endtask

    task automatic idle();
        applyStimulus(10'd800, 1'b0, 1'b0);
    endtask

    // Reference model: line phase derived directly from the line number.
    always begin
        logic [9:0] sh;
        logic st, sr, ss;
        int expV;
        logic [34:0] expVec, gotVec;
        @(posedge clk);
        sh = bus.h_count; st = bus.trig_v; sr = rst; ss = statOn;
        if (sr) begin
            expVec = {10'd0, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0};
            mV = 0; mErr = 1'b0; mValid = 1'b1;
        end else begin
            expV = st ? ((mV == V_TOTAL - 1) ? 0 : mV + 1) : mV;
            mErr = mErr || (st && sh != 10'(H_TOTAL - 1));
            expVec = {10'(expV),
                      !(sh >= 10'd656 && sh < 10'd752),
                      !(mV >= 490 && mV < 492),
                      (sh < 10'd640) && (mV < 480),
                      sh, 10'(mV),
                      (sh == 10'd0) && (mV == 0),
                      mErr};
            mV = expV;
        end
        #1;
        if (mValid) begin
            gotVec = {bus.v_count, bus.hsync, bus.vsync, bus.video_on,
                      bus.pix_x, bus.pix_y, bus.frame_start, bus.sync_err};
            checkOutput($sformatf("outputs@%0t", $time), 64'(gotVec), 64'(expVec));
        end
        if (ss) begin
            if (!bus.hsync) begin
                hsLow++;
                if (int'(bus.pix_x) < hsMinX) hsMinX = int'(bus.pix_x);
                if (int'(bus.pix_x) > hsMaxX) hsMaxX = int'(bus.pix_x);
            end
            if (bus.video_on) begin
                voHigh++;
                if (int'(bus.pix_x) < voMinX) voMinX = int'(bus.pix_x);
                if (int'(bus.pix_x) > voMaxX) voMaxX = int'(bus.pix_x);
            end
            if (!bus.vsync) begin
                vsLow++;
                if (int'(bus.pix_y) < vsMinY) vsMinY = int'(bus.pix_y);
                if (int'(bus.pix_y) > vsMaxY) vsMaxY = int'(bus.pix_y);
            end
            if (bus.frame_start) begin
                fsCount++;
                fsX = int'(bus.pix_x);
                fsY = int'(bus.pix_y);
            end
            if (prevV == V_TOTAL - 1 && int'(bus.v_count) == 0) wraps++;
        end
        prevV = int'(bus.v_count);
    end

    initial begin
        int mode;
        int hRun;
        bus.h_count = 10'd800;
        bus.trig_v  = 1'b0;
        clearStats();

        applyStimulus(10'd800, 1'b0, 1'b1);
        applyStimulus(10'd800, 1'b0, 1'b0);
        waitOut();
        checkOutput("reset_v_count", 64'(bus.v_count), 64'd0);
        checkOutput("reset_hsync", 64'(bus.hsync), 64'd1);

        $display("[TB] reset at line 200");
        fastForward(200);
        waitOut();
        checkOutput("at_line_200", 64'(bus.v_count), 64'd200);
        for (int i = 0; i < 3; i++) applyStimulus(10'd700, 1'b1, 1'b1);
        waitOut();
        checkOutput("rst200_v_count", 64'(bus.v_count), 64'd0);
        checkOutput("rst200_vsync", 64'(bus.vsync), 64'd1);
        checkOutput("rst200_hsync", 64'(bus.hsync), 64'd1);
        checkOutput("rst200_video_on", 64'(bus.video_on), 64'd0);
        checkOutput("rst200_sync_err", 64'(bus.sync_err), 64'd0);

        $display("[TB] full frame wrap and frame_start");
        clearStats();
        statOn = 1'b1;
        fastForward(V_TOTAL);
        driveLine();
        statOn = 1'b0;
        idle();
        checkOutput("frame_wraps", 64'(wraps), 64'd1);
        checkOutput("frame_start_count", 64'(fsCount), 64'd1);
        checkOutput("frame_start_pix_x", 64'(fsX), 64'd0);
        checkOutput("frame_start_pix_y", 64'(fsY), 64'd0);

        $display("[TB] line 10 horizontal timing");
        fastForward(9);
        clearStats();
        statOn = 1'b1;
        driveLine();
        statOn = 1'b0;
        idle();
        checkOutput("hsync_low_cycles", 64'(hsLow), 64'd96);
        checkOutput("hsync_first_x", 64'(hsMinX), 64'd656);
        checkOutput("hsync_last_x", 64'(hsMaxX), 64'd751);
        checkOutput("video_on_cycles", 64'(voHigh), 64'd640);
        checkOutput("video_on_first_x", 64'(voMinX), 64'd0);
        checkOutput("video_on_last_x", 64'(voMaxX), 64'd639);

        $display("[TB] vertical sync lines");
        fastForward(478);
        clearStats();
        statOn = 1'b1;
        for (int l = 0; l < 4; l++) driveLine();
        statOn = 1'b0;
        idle();
        checkOutput("vsync_low_cycles", 64'(vsLow), 64'd1600);
        checkOutput("vsync_first_y", 64'(vsMinY), 64'd490);
        checkOutput("vsync_last_y", 64'(vsMaxY), 64'd491);
        checkOutput("video_on_blank_lines", 64'(voHigh), 64'd0);

        $display("[TB] spurious line strobe");
        applyStimulus(10'd300, 1'b1, 1'b0);
        waitOut();
        checkOutput("spurious_sync_err", 64'(bus.sync_err), 64'd1);
        checkOutput("spurious_v_count", 64'(bus.v_count), 64'd494);
        driveLine();
        idle();
        waitOut();
        checkOutput("sync_err_sticky", 64'(bus.sync_err), 64'd1);
        checkOutput("after_line_v_count", 64'(bus.v_count), 64'd495);

        $display("[TB] reset colliding with strobe at last line");
        fastForward(29);
        waitOut();
        checkOutput("at_last_line", 64'(bus.v_count), 64'd524);
        applyStimulus(10'd0, 1'b1, 1'b1);
        waitOut();
        checkOutput("collide_v_count", 64'(bus.v_count), 64'd0);
        checkOutput("collide_sync_err", 64'(bus.sync_err), 64'd0);
        checkOutput("collide_frame_start", 64'(bus.frame_start), 64'd0);
        applyStimulus(10'd5, 1'b0, 1'b0);
        waitOut();
        checkOutput("collide_state_active", 64'(bus.video_on), 64'd1);

        $display("[TB] randomized traffic");
        hRun = 0;
        mode = 0;
        for (int c = 0; c < 4000; c++) begin
            if (c % 50 == 0) mode = int'($urandom_range(0, 2));
            if ($urandom_range(0, 199) == 0) begin
                applyStimulus(10'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)), 1'b1);
            end else if (mode == 0) begin
                applyStimulus(10'(hRun), (hRun == H_TOTAL - 1), 1'b0);
                hRun = (hRun == H_TOTAL - 1) ? 0 : hRun + 1;
            end else if (mode == 1) begin
                applyStimulus(10'd799, 1'b1, 1'b0);
            end else begin
                applyStimulus(10'($urandom_range(0, 1023)), ($urandom_range(0, 7) == 0), 1'b0);
            end
        end
        idle();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
